// File: rtl/sorter_pkg.sv
// Shared sorter types plus the group map used by the top-k result reader:
// 15 groups (8 x 4, 4 x 8, 2 x 16, 1 x 32) packed into a 128-entry snapshot.
package sorter_pkg;

    localparam int DATAWIDTH  = 8;
    localparam int NUM_ELEMS  = 32;
    localparam int NUM_GROUPS = 15;
    localparam int GROUP_ID_W = 4;
    localparam int SNAP_DEPTH = 128;
    localparam int SNAP_AW    = 7;

    localparam logic [GROUP_ID_W-1:0] BASE_ID_4  = 4'd0;
    localparam logic [GROUP_ID_W-1:0] BASE_ID_8  = 4'd8;
    localparam logic [GROUP_ID_W-1:0] BASE_ID_16 = 4'd12;
    localparam logic [GROUP_ID_W-1:0] BASE_ID_32 = 4'd14;

    typedef struct packed {
        logic [NUM_ELEMS-1:0][DATAWIDTH-1:0] data;
        logic [7:0]                          channel_4;
        logic [3:0]                          channel_8;
        logic [1:0]                          channel_16;
        logic                                channel_32;
    } sorter_top_io_t;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} reader_state_t;

    function automatic logic [5:0] group_size(input logic [GROUP_ID_W-1:0] id);
        if (id < BASE_ID_8)       return 6'd4;
        else if (id < BASE_ID_16) return 6'd8;
        else if (id < BASE_ID_32) return 6'd16;
        else                      return 6'd32;
    endfunction

    // Position of the group's element 0 within the sorter's 32-element data vector.
    function automatic logic [4:0] group_src(input logic [GROUP_ID_W-1:0] id);
        if (id < BASE_ID_8)       return {id[2:0], 2'b00};
        else if (id < BASE_ID_16) return {id[1:0], 3'b000};
        else if (id < BASE_ID_32) return {id[0], 4'b0000};
        else                      return 5'd0;
    endfunction

    // Position of the group's element 0 within the flat snapshot buffer.
    function automatic logic [SNAP_AW-1:0] group_base(input logic [GROUP_ID_W-1:0] id);
        if (id < BASE_ID_8)       return {2'b00, id[2:0], 2'b00};
        else if (id < BASE_ID_16) return 7'd32 + {2'b00, id[1:0], 3'b000};
        else if (id < BASE_ID_32) return 7'd64 + {2'b00, id[0], 4'b0000};
        else                      return 7'd96;
    endfunction

endpackage

// File: rtl/topk_group_arbiter.sv
// Lowest-index-first priority encoder over the pending-group mask.
module topk_group_arbiter
    import sorter_pkg::*;
(
    input  logic [NUM_GROUPS-1:0] pending,
    output logic [GROUP_ID_W-1:0] id,
    output logic                  any
);

    always_comb begin
        id = '0;
        for (int i = NUM_GROUPS - 1; i >= 0; i--) begin
            if (pending[i]) id = GROUP_ID_W'(i);
        end
        any = |pending;
    end

endmodule

// File: rtl/topk_result_reader.sv
// Captures sorter output groups into snapshots and streams the first k elements
// of each over valid/ready. Define TOPK_READER_REVERSE_EN for bottom-k via reverse_i.
module topk_result_reader
    import sorter_pkg::*;
#(
    parameter int DATAWIDTH = sorter_pkg::DATAWIDTH,
    parameter int KW        = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  sorter_top_io_t        sorter_io_i,
    input  logic [KW-1:0]         k_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATAWIDTH-1:0]  out_data_o,
    output logic [GROUP_ID_W-1:0] out_group_o,
    output logic [4:0]            out_idx_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  overflow_o,
    input  logic                  clr_overflow_i
`ifdef TOPK_READER_REVERSE_EN
    ,
    input  logic                  reverse_i
`endif
);

    reader_state_t         state, state_next;
    logic [NUM_GROUPS-1:0] pending, pending_next, chan, accept, clear_mask;
    logic [GROUP_ID_W-1:0] arb_id, cur_id, sel_id;
    logic                  arb_any;
    logic [5:0]            n, n_load, sel_n, sel_size, arb_size;
    logic [4:0]            cnt, sel_cnt, sel_idx;
    logic                  rev, rev_in, sel_rev, sel_last;
    logic                  load, advance, done, ovf_event;
    logic [SNAP_AW-1:0]    rd_addr;
    logic [DATAWIDTH-1:0]  snap [SNAP_DEPTH];

`ifdef TOPK_READER_REVERSE_EN
    assign rev_in = reverse_i;
`else
    assign rev_in = 1'b0;
`endif

    assign chan = {sorter_io_i.channel_32, sorter_io_i.channel_16,
                   sorter_io_i.channel_8, sorter_io_i.channel_4};

    topk_group_arbiter u_arb (
        .pending (pending),
        .id      (arb_id),
        .any     (arb_any)
    );

    // A re-announce landing on the group's final handshake refills it instead of overflowing.
    always_comb begin
        clear_mask = '0;
        if (done) clear_mask[cur_id] = 1'b1;
        accept       = chan & (~pending | clear_mask);
        ovf_event    = |(chan & pending & ~clear_mask);
        pending_next = (pending & ~clear_mask) | accept;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE:   if (arb_any) state_next = LOAD;
            LOAD: begin
                load       = 1'b1;
                state_next = STREAM;
            end
            STREAM: begin
                if (out_ready_i) begin
                    if (out_last_o) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered one element ahead, so LOAD preloads element 0.
    always_comb begin
        arb_size = group_size(arb_id);
        if (k_i == '0 || int'(k_i) >= int'(arb_size)) n_load = arb_size;
        else                                           n_load = 6'(k_i);
        sel_id   = load ? arb_id : cur_id;
        sel_size = group_size(sel_id);
        sel_cnt  = load ? 5'd0 : cnt + 5'd1;
        sel_rev  = load ? rev_in : rev;
        sel_n    = load ? n_load : n;
        sel_idx  = sel_rev ? 5'(sel_size - 6'd1 - {1'b0, sel_cnt}) : sel_cnt;
        sel_last = ({1'b0, sel_cnt} == sel_n - 6'd1);
        rd_addr  = group_base(sel_id) + {2'b00, sel_idx};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending     <= '0;
            overflow_o  <= 1'b0;
            cnt         <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            out_data_o  <= '0;
            out_group_o <= '0;
            out_idx_o   <= '0;
        end else begin
            pending <= pending_next;
            if (ovf_event)           overflow_o <= 1'b1;
            else if (clr_overflow_i) overflow_o <= 1'b0;
            if (load || advance) begin
                out_valid_o <= 1'b1;
                out_data_o  <= snap[rd_addr];
                out_group_o <= sel_id;
                out_idx_o   <= sel_idx;
                out_last_o  <= sel_last;
                cnt         <= sel_cnt;
            end else if (done) begin
                out_valid_o <= 1'b0;
                out_last_o  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (load) begin
            cur_id <= arb_id;
            n      <= n_load;
            rev    <= rev_in;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (accept[g]) begin
                for (int e = 0; e < NUM_ELEMS; e++) begin
                    if (e < int'(group_size(GROUP_ID_W'(g))))
                        snap[SNAP_AW'(int'(group_base(GROUP_ID_W'(g))) + e)] <=
                            sorter_io_i.data[5'(int'(group_src(GROUP_ID_W'(g))) + e)];
                end
            end
        end
    end

    assign busy_o = arb_any || (state != IDLE);

endmodule

// File: tb/tb_topk_result_reader.sv
// Self-checking bench for topk_result_reader: directed scenarios plus randomized
// group bursts scored against an element-level model of the expected stream.
module tb_topk_result_reader;

    logic                           clk = 1'b0;
    logic                           rst = 1'b1;
    sorter_pkg::sorter_top_io_t     io;
    logic [5:0]                     k;
    logic                           ready = 1'b1;
    logic                           clr;
    logic                           rev;
    logic                           out_valid, out_last, busy, overflow;
    logic [7:0]                     out_data;
    logic [3:0]                     out_group;
    logic [4:0]                     out_idx;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int rmode = 0;
    int phase = 0;

    logic [7:0] vec [32];
    logic [7:0] snap [15][32];

    typedef struct {
        logic [3:0] grp;
        logic [4:0] idx;
        logic [7:0] data;
        logic       last;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    logic        stalled = 1'b0;
    logic [18:0] prev_out;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    topk_result_reader dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sorter_io_i    (io),
        .k_i            (k),
        .out_valid_o    (out_valid),
        .out_ready_i    (ready),
        .out_data_o     (out_data),
        .out_group_o    (out_group),
        .out_idx_o      (out_idx),
        .out_last_o     (out_last),
        .busy_o         (busy),
        .overflow_o     (overflow),
        .clr_overflow_i (clr)
`ifdef TOPK_READER_REVERSE_EN
        ,
        .reverse_i      (rev)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int gsize(input int id);
        if (id < 8)  return 4;
        if (id < 12) return 8;
        if (id < 14) return 16;
        return 32;
    endfunction

    function automatic int gsrc(input int id);
        if (id < 8)  return 4 * id;
        if (id < 12) return 8 * (id - 8);
        if (id < 14) return 16 * (id - 12);
        return 0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_io(input logic [14:0] mask);
        for (int i = 0; i < 32; i++) io.data[i] = vec[i];
        {io.channel_32, io.channel_16, io.channel_8, io.channel_4} = mask;
    endtask

    // Announce the groups in mask for one cycle; the model keeps only those in acc.
    task automatic pulse(input logic [14:0] mask, input logic [14:0] acc);
        drive_io(mask);
        for (int id = 0; id < 15; id++)
            if (acc[id])
                for (int e = 0; e < gsize(id); e++) snap[id][e] = vec[gsrc(id) + e];
        tick;
        drive_io('0);
    endtask

    task automatic push_elem(input int id, input int i, input bit rv, input int n, input int c);
        exp_t e;
        int   ix;
        ix     = rv ? gsize(id) - 1 - i : i;
        e.grp  = 4'(id);
        e.idx  = 5'(ix);
        e.data = snap[id][ix];
        e.last = (i == n - 1);
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic push_group(input int id, input int kk, input bit rv, input int start,
                              output int lastc);
        int sz, n;
        sz = gsize(id);
        n  = (kk == 0 || kk >= sz) ? sz : kk;
        for (int i = 0; i < n; i++) push_elem(id, i, rv, n, (start < 0) ? -1 : start + i);
        lastc = start + n - 1;
    endtask

    task automatic drain;
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            tick;
            t++;
        end
        chk("drain_timeout", 64'(t >= 3000), 64'(0));
        repeat (4) tick;
    endtask

    task automatic rand_vec;
        for (int i = 0; i < 32; i++) vec[i] = 8'($urandom);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                1: ready = 1'($urandom_range(0, 1));
                2: begin
                    ready = (phase == 0);
                    phase = (phase + 1) % 3;
                end
                default: ready = 1'b1;
            endcase
        end
    end

    initial begin
        logic [18:0] cur;
        exp_t        e;
        forever begin
            @(negedge clk);
            cur = {out_valid, out_group, out_idx, out_data, out_last};
            if (stalled) chk("hold", 64'(cur), 64'(prev_out));
            if (out_valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious", 64'(out_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("elem", 64'({out_group, out_idx, out_data, out_last}),
                        64'({e.grp, e.idx, e.data, e.last}));
                    if (e.cyc >= 0) chk("elem_cyc", 64'(cyc), 64'(e.cyc));
                end
            end
            stalled  = out_valid && !ready;
            prev_out = cur;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, lc, lc2;
        logic [14:0] mask;
        io  = '0;
        k   = '0;
        clr = 1'b0;
        rev = 1'b0;
        for (int i = 0; i < 32; i++) vec[i] = '0;
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_last", 64'(out_last), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_group", 64'(out_group), 64'(0));
        chk("rst_idx", 64'(out_idx), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        tick;

        // channel_32 with data[i] = i, k = 5
        k = 6'd5;
        for (int i = 0; i < 32; i++) vec[i] = 8'(i);
        c = cyc;
        pulse(15'h4000, 15'h4000);
        push_group(14, 5, 1'b0, c + 3, lc);
        drain;

        // three groups at once, k = 0, lowest id first with two-cycle gaps
        k = 6'd0;
        rand_vec;
        c = cyc;
        mask = 15'h0209;
        pulse(mask, mask);
        push_group(0, 0, 1'b0, c + 3, lc);
        push_group(3, 0, 1'b0, lc + 3, lc);
        push_group(9, 0, 1'b0, lc + 3, lc);
        drain;

        // k larger than the group, ready pattern 1,0,0
        k = 6'd20;
        rand_vec;
        rmode = 2;
        phase = 0;
        pulse(15'h2000, 15'h2000);
        push_group(13, 20, 1'b0, -1, lc);
        drain;
        rmode = 0;

        // re-announce while streaming, then exactly on the last handshake
        k = 6'd0;
        rand_vec;
        c = cyc;
        pulse(15'h0100, 15'h0100);
        push_group(8, 0, 1'b0, c + 3, lc);
        while (cyc < c + 5) tick;
        rand_vec;
        pulse(15'h0100, 15'h0000);
        @(negedge clk);
        chk("ovf_set", 64'(overflow), 64'(1));
        tick;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        @(negedge clk);
        chk("ovf_clr", 64'(overflow), 64'(0));
        while (cyc < lc) tick;
        rand_vec;
        pulse(15'h0100, 15'h0100);
        push_group(8, 0, 1'b0, lc + 3, lc2);
        @(negedge clk);
        chk("ovf_last_hs", 64'(overflow), 64'(0));
        chk("busy_refill", 64'(busy), 64'(1));
        while (cyc < lc + 5) tick;
        rand_vec;
        clr = 1'b1;
        pulse(15'h0100, 15'h0000);
        clr = 1'b0;
        @(negedge clk);
        chk("ovf_set_beats_clr", 64'(overflow), 64'(1));
        tick;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        drain;
        chk("ovf_final", 64'(overflow), 64'(0));

        // reset mid-group with two groups pending
        k = 6'd0;
        rand_vec;
        c = cyc;
        pulse(15'h0006, 15'h0006);
        push_elem(1, 0, 1'b0, 4, c + 3);
        push_elem(1, 1, 1'b0, 4, c + 4);
        while (cyc < c + 4) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        repeat (12) tick;
        chk("mid_rst_queue", 64'(exp_q.size()), 64'(0));
        chk("mid_rst_idle", 64'(busy), 64'(0));

`ifdef TOPK_READER_REVERSE_EN
        // bottom-3 of channel_8[2] with data[i] = 10+i
        k = 6'd3;
        rev = 1'b1;
        rand_vec;
        for (int i = 0; i < 8; i++) vec[16 + i] = 8'(10 + i);
        c = cyc;
        pulse(15'h0400, 15'h0400);
        push_group(10, 3, 1'b1, c + 3, lc);
        drain;
        rev = 1'b0;
`endif

        // randomized bursts: all groups announced together drain in ascending id order
        for (int b = 0; b < 25; b++) begin
            rmode = int'($urandom_range(0, 1));
            k     = 6'($urandom_range(0, 40));
`ifdef TOPK_READER_REVERSE_EN
            rev   = 1'($urandom_range(0, 1));
`endif
            rand_vec;
            mask = 15'($urandom_range(1, 32767));
            pulse(mask, mask);
            for (int id = 0; id < 15; id++)
                if (mask[id]) push_group(id, int'(k), rev, -1, lc);
            drain;
        end
        rmode = 0;

        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
